// File: rtl/wb_controller.sv
// Write-back controller: merges single-cycle ALU results with buffered
// variable-latency load results onto the register-file write port, and keeps
// a per-register busy scoreboard that stalls issue while a load is pending.

module wb_controller #(
  parameter int XLEN       = 32,
  parameter int LOAD_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [4:0]                    ld_rd,
  input  logic [XLEN-1:0]               ld_data,
  input  logic                          mark_valid,
  input  logic [4:0]                    mark_rd,
  input  logic [4:0]                    chk_rs1,
  input  logic [4:0]                    chk_rs2,
  input  logic [4:0]                    chk_rd,
  output logic                          stall,
  output logic [4:0]                    rd,
  output logic [XLEN-1:0]               rd_data,
  output logic                          reg_write,
  output logic [$clog2(LOAD_DEPTH):0]   ld_count
);

  localparam int AW = $clog2(LOAD_DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      fifo_rd   [LOAD_DEPTH];
  logic [XLEN-1:0] fifo_data [LOAD_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            push;
  logic            pop;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wb_is_load;
  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic [31:0]     busy_vis;

  assign ld_count = count;

  // Handshake and arbitration: ALU wins; the FIFO head drains only in idle ALU cycles.
  always_comb begin
    ld_ready  = !reset && (count < CW'(LOAD_DEPTH));
    push      = ld_valid && ld_ready;
    pop       = !alu_valid && (count != {CW{1'b0}});
    sel_valid = 1'b0;
    sel_rd    = 5'd0;
    sel_data  = {XLEN{1'b0}};
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
    end else begin
      sel_valid = 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until the count says otherwise.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Register-file write port; x0 targets are consumed but never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write  <= 1'b0;
      wb_is_load <= 1'b0;
      rd         <= 5'd0;
      rd_data    <= {XLEN{1'b0}};
    end else begin
      reg_write  <= sel_valid && (sel_rd != 5'd0);
      wb_is_load <= pop;
      if (sel_valid) begin
        rd      <= sel_rd;
        rd_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: clear on load commit, then set on mark so set wins.
  always_comb begin
    busy_next = busy;
    if (reg_write && wb_is_load) begin
      busy_next[rd] = 1'b0;
    end else begin
      busy_next = busy_next;
    end
    if (mark_valid && (mark_rd != 5'd0)) begin
      busy_next[mark_rd] = 1'b1;
    end else begin
      busy_next = busy_next;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= 32'd0;
    else       busy <= busy_next;
  end

  // Stall lookup; x0 is never busy.
  always_comb begin
    busy_vis = {busy[31:1], 1'b0};
    stall    = busy_vis[chk_rs1] | busy_vis[chk_rs2] | busy_vis[chk_rd];
  end

`ifndef SYNTHESIS
  wb_controller_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .busy      (busy_vis)
  );
`endif

endmodule

// Simulation checker: an ALU result must never target a register awaiting a load.
module wb_controller_chk (
  input logic        clk,
  input logic        reset,
  input logic        alu_valid,
  input logic [4:0]  alu_rd,
  input logic [31:0] busy
);
  // Flag ALU writes to registers with a pending load.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(alu_valid && busy[alu_rd]))
        else $error("illegal ALU write to busy register x%0d", alu_rd);
    end
  end
endmodule

// File: tb/tb_wb_controller.sv
// Self-checking bench for wb_controller: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.

module tb_wb_controller;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            mark_valid;
  logic [4:0]      mark_rd;
  logic [4:0]      chk_rs1, chk_rs2, chk_rd;
  logic            stall;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_data;
  logic            reg_write;
  logic [1:0]      ld_count;

  wb_controller #(.XLEN(XLEN), .LOAD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .mark_valid(mark_valid), .mark_rd(mark_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall), .rd(rd), .rd_data(rd_data), .reg_write(reg_write),
    .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic [31:0] mbusy;
  logic        exp_we, exp_is_load, exp_zero;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic busy_of(input logic [4:0] r);
    return (r != 5'd0) && mbusy[r];
  endfunction

  task automatic check_outputs();
    chk("reg_write", 64'(reg_write), 64'(exp_we));
    if (exp_we || exp_zero) begin
      chk("rd", 64'(rd), 64'(exp_rd));
      chk("rd_data", 64'(rd_data), 64'(exp_data));
    end
    chk("ld_count", 64'(ld_count), 64'(q_rd.size()));
    chk("ld_ready", 64'(ld_ready), 64'(!reset && (q_rd.size() < DEPTH)));
    chk("stall", 64'(stall), 64'(busy_of(chk_rs1) | busy_of(chk_rs2) | busy_of(chk_rd)));
  endtask

  // Advance the model across one clock edge using the inputs held during the cycle.
  task automatic tick();
    int   had;
    logic push_ok;
    if (reset) begin
      q_rd.delete(); q_data.delete();
      mbusy = 32'd0; exp_we = 1'b0; exp_is_load = 1'b0;
      exp_rd = 5'd0; exp_data = 32'd0; exp_zero = 1'b1;
    end else begin
      had     = q_rd.size();
      push_ok = ld_valid && (had < DEPTH);
      if (exp_we && exp_is_load) mbusy[exp_rd] = 1'b0;
      if (mark_valid && mark_rd != 5'd0) mbusy[mark_rd] = 1'b1;
      if (alu_valid) begin
        exp_rd = alu_rd; exp_data = alu_data; exp_we = (alu_rd != 5'd0);
        exp_is_load = 1'b0; exp_zero = 1'b0;
      end else if (had > 0) begin
        exp_rd = q_rd.pop_front(); exp_data = q_data.pop_front();
        exp_we = (exp_rd != 5'd0); exp_is_load = 1'b1; exp_zero = 1'b0;
      end else begin
        exp_we = 1'b0; exp_is_load = 1'b0;
      end
      if (push_ok) begin
        q_rd.push_back(ld_rd);
        q_data.push_back(ld_data);
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    tick();
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; mark_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] pl [3];
    int         idx;
    logic       acc;
    pl[0] = 5'd8; pl[1] = 5'd9; pl[2] = 5'd10;

    // Reset held for three edges with a load offered
    reset = 1'b1; idle(); ld_valid = 1'b1;
    alu_rd = 5'd0; alu_data = 32'd0; ld_rd = 5'd0; ld_data = 32'd0;
    mark_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;
    @(posedge clk); tick(); #1;
    step();
    step();
    reset = 1'b0; ld_valid = 1'b0;
    step();

    // ALU write visible the following cycle only
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    step();
    chk("alu_write", {31'd0, reg_write, rd, rd_data}, {31'd0, 1'b1, 5'd5, 32'h0000_1234});
    idle();
    step();
    step();

    // Load with scoreboard stall on x7
    mark_valid = 1'b1; mark_rd = 5'd7;
    step();
    mark_valid = 1'b0; chk_rs1 = 5'd7;
    step();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD_BEEF;
    step();                       // cycle N
    ld_valid = 1'b0;
    step();                       // N+1: pop
    chk("load_we", {63'd0, reg_write}, 64'd1);
    step();                       // N+2: write committed
    chk("load_stall_clear", {63'd0, stall}, 64'd0);
    step();                       // N+3
    chk_rs1 = 5'd0;

    // Priority and fullness: ALU busy for 4 cycles while loads queue up
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      alu_valid = (c < 4); alu_rd = 5'(c + 1); alu_data = 32'(c);
      ld_valid  = (idx < 3);
      ld_rd     = pl[idx < 3 ? idx : 2];
      ld_data   = 32'h100 + 32'(idx);
      acc       = ld_valid && (q_rd.size() < DEPTH);
      step();
      if (acc) idx++;
      if (c == 3) chk("full_held", 64'(idx), 64'd2);
    end
    idle();

    // x0 handling
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    idle(); mark_valid = 1'b1; mark_rd = 5'd0; chk_rs1 = 5'd0;
    step();
    mark_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h77;
    step();
    ld_valid = 1'b0;
    step();
    step();
    chk("x0_drained", {62'd0, ld_count}, 64'd0);

    // Set/clear collision on x3
    mark_valid = 1'b1; mark_rd = 5'd3;
    step();
    mark_valid = 1'b0; ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h333;
    step();                       // N
    ld_valid = 1'b0;
    step();                       // N+1 pop
    mark_valid = 1'b1; mark_rd = 5'd3; chk_rs2 = 5'd3;
    step();                       // N+2 write + re-mark
    mark_valid = 1'b0;
    step();
    chk("collision_stall", {63'd0, stall}, 64'd1);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h444;
    step();
    ld_valid = 1'b0;
    step(); step(); step();
    chk_rs2 = 5'd0;

    // Reset mid-operation discards queued loads and busy bits
    mark_valid = 1'b1; mark_rd = 5'd12;
    alu_valid = 1'b1; alu_rd = 5'd1; ld_valid = 1'b1; ld_rd = 5'd12;
    step(); step();
    mark_valid = 1'b0; reset = 1'b1;
    step();
    chk("reset_no_write", {63'd0, reg_write}, 64'd0);
    reset = 1'b0; idle(); chk_rd = 5'd12;
    step();
    chk_rd = 5'd0;

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      alu_rd     = 5'($urandom_range(0, 31));
      alu_valid  = ($urandom_range(0, 2) == 0) && !busy_of(alu_rd);
      alu_data   = $urandom;
      ld_valid   = ($urandom_range(0, 1) == 1);
      ld_rd      = 5'($urandom_range(0, 31));
      ld_data    = $urandom;
      mark_valid = ($urandom_range(0, 3) == 0);
      mark_rd    = 5'($urandom_range(0, 31));
      chk_rs1    = 5'($urandom_range(0, 31));
      chk_rs2    = 5'($urandom_range(0, 31));
      chk_rd     = 5'($urandom_range(0, 31));
      step();
    end
    reset = 1'b0; idle();
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_controller.md
# wb_controller

Write-back controller that drives the write port of the integer register file: `rd`, `rd_data` and `reg_write`. It merges single-cycle ALU results with variable-latency load results. Load results are buffered in a small FIFO. A per-register busy scoreboard stalls issue while a load result is still pending. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `XLEN`, default 32: data width.
- `LOAD_DEPTH`, default 2: load FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: system clock; the block has one clock.
- `reset`, in, 1: synchronous, active-high reset.
- `alu_valid`, in, 1: ALU result present this cycle; cannot be back-pressured.
- `alu_rd`, in, 5: ALU destination register.
- `alu_data`, in, XLEN: ALU result.
- `ld_valid`, in, 1: load result offered.
- `ld_ready`, out, 1: FIFO can accept a load result.
- `ld_rd`, in, 5: load destination register.
- `ld_data`, in, XLEN: load result.
- `mark_valid`, in, 1: a load was issued this cycle.
- `mark_rd`, in, 5: register to mark busy.
- `chk_rs1`, `chk_rs2`, `chk_rd`, in, 5 each: registers of the instruction in issue.
- `stall`, out, 1: the instruction in issue must wait.
- `rd`, out, 5: register-file write address.
- `rd_data`, out, XLEN: register-file write data.
- `reg_write`, out, 1: register-file write enable.
- `ld_count`, out, log2(LOAD_DEPTH)+1: current FIFO occupancy.

## Operation
- **Load FIFO.** A push happens when `ld_valid && ld_ready`.
  - `ld_ready = !reset && (ld_count < LOAD_DEPTH)`.
  - There is no push-on-pop when the FIFO is full.
- **Arbitration**, evaluated each cycle:
  - If `alu_valid`, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the head entry is popped and selected.
  - Otherwise nothing is selected.
  - The ALU always has priority. Loads drain only in cycles with no ALU result, in FIFO order.
- **Output register.** `rd`, `rd_data`, `reg_write` and an internal `wb_is_load` flag are registered from the selection.
  - `reg_write = selected && (sel_rd != 0)`.
  - A popped entry addressed to x0 is consumed, but no write is issued.
- **Scoreboard.** A 32-bit `busy` register.
  - Set: `busy[mark_rd]` is set on `mark_valid`; `mark_rd == 0` is ignored.
  - Clear: `busy[rd]` is cleared at the edge that ends a cycle in which `reg_write && wb_is_load`, i.e. when the register file commits the write.
  - If a set and a clear hit the same register at the same edge, the set wins.
- **Stall.** `stall = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]`, with index 0 always read as not busy.
  - `stall` is combinational from `busy`, with no bypass.
  - Including `chk_rd` prevents write-after-write hazards.
- **Illegal input.** `alu_valid` with `busy[alu_rd]` set is illegal; the simulation-only assertion flags it.

## Timing
- Reset values: `busy = 0`, `ld_count = 0`, FIFO pointers = 0, `rd = 0`, `rd_data = 0`, `reg_write = 0`, `wb_is_load = 0`, `ld_ready = 0` while `reset` is high, `stall = 0`.
- Reset asserted mid-operation discards all FIFO contents and pending busy bits. No write is issued in the cycle after reset is asserted.
- ALU latency: `alu_valid` in cycle N gives `reg_write` in cycle N+1.
- Load latency: accepted in cycle N; earliest pop is in cycle N+1; `reg_write` is high in cycle N+2; the busy bit clears at the end of N+2, so `stall` falls in N+3.
  - Each ALU-occupied cycle delays the load by one cycle.
- FIFO full: `ld_ready` is low in the same cycle `ld_count` reaches LOAD_DEPTH. It rises in the cycle after a pop.
- Simultaneous push into an empty FIFO and an idle arbiter: no pop in that cycle, since the entry becomes visible next cycle.
- Pointers wrap modulo LOAD_DEPTH; `ld_count` never exceeds LOAD_DEPTH.
- At most one register-file write per cycle.

## Test plan
- Reset: hold `reset` for 3 cycles with `ld_valid = 1` → all outputs 0 and `ld_ready = 0` during reset; `ld_ready = 1` in the first cycle after release.
- ALU write: `alu_valid`, `alu_rd = 5`, `alu_data = 0x00001234` in cycle N → `reg_write = 1`, `rd = 5`, `rd_data = 0x1234` in cycle N+1 only.
- Load and scoreboard: `mark_rd = 7`, then `chk_rs1 = 7` → `stall = 1`; push `ld_rd = 7`, `ld_data = 0xDEADBEEF` in cycle N → `reg_write` in N+2, `stall = 0` from N+3.
- Priority and fullness (LOAD_DEPTH = 2):
  - Setup: `alu_valid` held high for 4 cycles; push loads to x8, x9 and x10.
  - During those 4 cycles: `ld_ready` falls after 2 pushes, and the x10 push is held.
  - After the ALU drops: writes to x8 and x9 in that order, then x10 is accepted and written.
- x0 handling: ALU write to rd 0 → `reg_write = 0`; `mark_rd = 0` with `chk_rs1 = 0` → `stall = 0`; a load to rd 0 drains `ld_count` with no write.
- Set/clear collision: a pending load on x3 retires in the same cycle `mark_rd = 3` is asserted → `busy[3]` stays 1 and `stall` remains high for `chk_rs2 = 3`.
